siteswap_scheduler: RTL and testbench
=====================================

// Module: siteswap_scheduler
// PURPOSE
//  Consumer of the validated siteswap from generate_pattern. On each beat, emits one throw event:
//   - throw height
//   - ball ID
//   - hand
//   - pattern position
//  Tracks every ball in flight in a landing-slot shift register, so downstream trajectory/render
//  logic knows which physical ball leaves which hand. Flags drops and collisions if a pattern ever
//  violates siteswap rules.
// PARAMETERS
//  MAX_LEN    7  max pattern length (entries of pattern_in)
//  MAX_THROW  7  max throw height; landing slots = MAX_THROW+1
//  W          3  bit width of throw heights, ball IDs, lengths
// PORTS
//  clk_in             in   1       system clock
//  rst_in             in   1       reset, asynchronous, active-high
//  new_beat           in   1       1-cycle beat strobe
//  pattern_in         in   W x7    throw heights [6:0], entry 0 thrown first
//  pattern_length     in   W       number of valid entries, 1..MAX_LEN
//  pattern_valid_in   in   1       level; high = pattern_in/num_balls_in are a valid siteswap
//  num_balls_in       in   W       ball count (sum/length) from generate_pattern
//  throw_valid_out    out  1       1-cycle pulse per beat while RUN
//  throw_height_out   out  W       height of this throw
//  ball_id_out        out  W       ball thrown; meaningless when throw_height_out==0
//  hand_out           out  1       0=right, 1=left; alternates every beat
//  pattern_pos_out    out  W       index of pattern entry used for this throw
//  error_out          out  1       sticky: drop/empty-throw/collision since last load
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; slots empty; fresh_cnt=0; hand=0; pos=0.
//  States:
//   IDLE: outputs 0. pattern_valid_in rising edge -> LOAD.
//   LOAD: 1 cycle.
//    - Latch pattern_in, pattern_length, num_balls_in into shadow regs.
//    - Clear slots, fresh_cnt, pos, hand, error_out.
//    - Then -> RUN.
//   RUN:  on each new_beat, compute one throw from shadow regs only (inputs ignored). Details below.
//   Any state: pattern_valid_in low -> IDLE next cycle, clears as reset (error_out also cleared).
//   RUN: pattern_valid_in re-rise -> LOAD (restart).
//  Slot model:
//   - slot[k] = {occ, id} = ball landing k beats from now.
//   - slot[0] = ball available this beat.
//  Per beat, with h = pattern[pos]:
//   - Ball source:
//     - slot[0].occ -> ball = slot[0].id
//     - else fresh_cnt < num_balls -> ball = fresh_cnt, fresh_cnt++
//     - else none
//   - h==0 with ball present -> drop: error_out=1, ball lost.
//   - h>0 with no ball -> empty throw: error_out=1, no insertion.
//   - Shift slots down by one: slot[k] <= slot[k+1], top slot empties.
//   - Insert ball at post-shift slot[h-1], i.e. it becomes available h beats later.
//   - Insert into an occupied slot -> collision: error_out=1, new ball overwrites.
//   - pos <= (pos == pattern_length-1) ? 0 : pos+1. No out-of-range index ever.
//   - hand <= ~hand.
//  Latency: new_beat at cycle N -> outputs registered, valid in cycle N+1.
//   - throw_valid_out high exactly that cycle.
//   - height/ball/hand/pos held until next beat.
//  Width rules:
//   - fresh_cnt W bits; compare against latched num_balls (0 balls = every nonzero throw errors).
//   - Heights > MAX_THROW cannot occur (W=3).
//  Simultaneous events:
//   - new_beat in LOAD cycle, or same cycle as pattern_valid_in edge: ignored, no throw.
//   - new_beat on consecutive cycles: each processed.
//   - Reset mid-RUN: immediate clear, no pulse.
//  Valid siteswaps never raise error_out. Ground-state and excited patterns are both supported
//  via fresh-ball injection.
// TESTING
//  1. "3", len1, 3 balls, 6 beats -> ball_id 0,1,2,0,1,2.
//     Heights 3. Hand 0,1,0,1,0,1. pos 0 always. error 0.
//  2. "441", len3, 3 balls, 7 beats -> ball_id 0,1,2,2,0,1,1.
//     pos 0,1,2,0,1,2,0. error 0.
//  3. "51", len2, 3 balls, 8 beats -> ball_id 0,1,1,2,2,0,0,1. error 0.
//  4. Invalid "30", len2, num_balls 2, 4 beats:
//     - beat0 throws ball0, beat1 h=0 no ball, beat2 throws ball1.
//     - beat3 ball0 lands with h=0 -> error_out=1 from cycle after beat3, and stays 1.
//  5. Drop pattern_valid_in mid-RUN, re-raise with "3"
//     -> IDLE, outputs 0, error clears; LOAD then first throw ball_id 0, pos 0, hand 0.
//  6. rst_in asserted mid-cycle during RUN
//     -> all outputs 0 immediately (async); beats ignored until valid rising edge.
//     Also: new_beat coincident with LOAD -> no throw_valid_out pulse.

Source files
------------

// File: rtl/siteswap_scheduler.sv
// Siteswap throw scheduler: steps a latched pattern one throw per beat and tracks every
// ball in flight in a landing-slot shift register, flagging drops, empty throws and collisions.
module siteswap_scheduler #(
    parameter int MAX_LEN   = 7,
    parameter int MAX_THROW = 7,
    parameter int W         = 3
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        new_beat,
    input  logic [MAX_LEN-1:0][W-1:0]   pattern_in,
    input  logic [W-1:0]                pattern_length,
    input  logic                        pattern_valid_in,
    input  logic [W-1:0]                num_balls_in,
    output logic                        throw_valid_out,
    output logic [W-1:0]                throw_height_out,
    output logic [W-1:0]                ball_id_out,
    output logic                        hand_out,
    output logic [W-1:0]                pattern_pos_out,
    output logic                        error_out
);

    localparam int SLOTS     = MAX_THROW + 1;
    localparam int PAT_SLOTS = 2 ** W;
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic                        r_valid_d;
    logic [PAT_SLOTS-1:0][W-1:0] r_pat;
    logic [W-1:0]                r_len;
    logic [W-1:0]                r_nb;
    logic [SLOTS-1:0]            r_occ;
    logic [SLOTS-1:0][W-1:0]     r_id;
    logic [W-1:0]                r_fresh;
    logic [W-1:0]                r_pos;
    logic                        r_hand;
    logic                        r_throw_valid;
    logic [W-1:0]                r_height;
    logic [W-1:0]                r_ball;
    logic                        r_hand_out;
    logic [W-1:0]                r_pos_out;
    logic                        r_error;

    logic                        w_rise;
    logic                        w_beat;
    logic [W-1:0]                w_h;
    logic [W-1:0]                w_slot_idx;
    logic                        w_from_slot;
    logic                        w_fresh;
    logic                        w_have;
    logic [W-1:0]                w_ball;
    logic                        w_collide;
    logic                        w_err;
    logic                        w_last;
    logic [W-1:0]                w_pos_nx;
    logic [SLOTS-1:0]            w_occ_nx;
    logic [SLOTS-1:0][W-1:0]     w_id_nx;

    assign w_rise = pattern_valid_in & ~r_valid_d;
    assign w_beat = (r_state == S_RUN) & new_beat & pattern_valid_in & ~w_rise;

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_valid_d <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_valid_d <= pattern_valid_in;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_state_nx = S_LOAD;
                else        w_state_nx = S_IDLE;
            end
            S_LOAD: begin
                if (pattern_valid_in) w_state_nx = S_RUN;
                else                  w_state_nx = S_IDLE;
            end
            S_RUN: begin
                if (!pattern_valid_in) w_state_nx = S_IDLE;
                else if (w_rise)       w_state_nx = S_LOAD;
                else                   w_state_nx = S_RUN;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Throw computation: ball source, slot shift, insertion and error detection
    always_comb begin
        w_h         = r_pat[r_pos];
        w_slot_idx  = w_h - ONE;
        w_from_slot = r_occ[0];
        // Fresh balls are only injected for a real throw, so a 0 with an empty hand is harmless
        w_fresh     = ~r_occ[0] & (w_h != ZERO) & (r_fresh < r_nb);
        w_have      = w_from_slot | w_fresh;
        w_ball      = w_from_slot ? r_id[0] : r_fresh;
        w_collide   = 1'b0;
        for (int k = 0; k < SLOTS - 1; k++) begin
            w_occ_nx[k] = r_occ[k+1];
            w_id_nx[k]  = r_id[k+1];
        end
        w_occ_nx[SLOTS-1] = 1'b0;
        w_id_nx[SLOTS-1]  = ZERO;
        if ((w_h != ZERO) && w_have) begin
            w_collide             = w_occ_nx[w_slot_idx];
            w_occ_nx[w_slot_idx]  = 1'b1;
            w_id_nx[w_slot_idx]   = w_ball;
        end else begin
            w_collide = 1'b0;
        end
        w_err    = ((w_h == ZERO) & w_from_slot) | ((w_h != ZERO) & ~w_have) | w_collide;
        w_last   = (r_pos == (r_len - ONE)) || (r_pos >= W'(MAX_LEN - 1));
        w_pos_nx = w_last ? ZERO : (r_pos + ONE);
    end

    // Shadow pattern, slot tracker and registered throw outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pat         <= '0;
            r_len         <= ZERO;
            r_nb          <= ZERO;
            r_occ         <= '0;
            r_id          <= '0;
            r_fresh       <= ZERO;
            r_pos         <= ZERO;
            r_hand        <= 1'b0;
            r_throw_valid <= 1'b0;
            r_height      <= ZERO;
            r_ball        <= ZERO;
            r_hand_out    <= 1'b0;
            r_pos_out     <= ZERO;
            r_error       <= 1'b0;
        end else if (!pattern_valid_in || (r_state == S_LOAD)) begin
            if (r_state == S_LOAD) begin
                for (int i = 0; i < MAX_LEN; i++) r_pat[i] <= pattern_in[i];
                for (int i = MAX_LEN; i < PAT_SLOTS; i++) r_pat[i] <= ZERO;
                r_len <= pattern_length;
                r_nb  <= num_balls_in;
            end
            r_occ         <= '0;
            r_id          <= '0;
            r_fresh       <= ZERO;
            r_pos         <= ZERO;
            r_hand        <= 1'b0;
            r_throw_valid <= 1'b0;
            r_height      <= ZERO;
            r_ball        <= ZERO;
            r_hand_out    <= 1'b0;
            r_pos_out     <= ZERO;
            r_error       <= 1'b0;
        end else if (w_beat) begin
            r_occ         <= w_occ_nx;
            r_id          <= w_id_nx;
            r_fresh       <= w_fresh ? (r_fresh + ONE) : r_fresh;
            r_pos         <= w_pos_nx;
            r_hand        <= ~r_hand;
            r_throw_valid <= 1'b1;
            r_height      <= w_h;
            r_ball        <= w_have ? w_ball : ZERO;
            r_hand_out    <= r_hand;
            r_pos_out     <= r_pos;
            r_error       <= r_error | w_err;
        end else begin
            r_throw_valid <= 1'b0;
        end
    end

    assign throw_valid_out  = r_throw_valid;
    assign throw_height_out = r_height;
    assign ball_id_out      = r_ball;
    assign hand_out         = r_hand_out;
    assign pattern_pos_out  = r_pos_out;
    assign error_out        = r_error;

endmodule

// File: tb/tb_siteswap_scheduler.sv
// Scoreboard bench for siteswap_scheduler: stimulus pushes expected throws, a negedge
// monitor pops one per throw_valid_out pulse and compares every field.
module tb_siteswap_scheduler;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             new_beat;
    logic [6:0][2:0]  pattern_in;
    logic [2:0]       pattern_length;
    logic             pattern_valid_in;
    logic [2:0]       num_balls_in;
    logic             throw_valid_out;
    logic [2:0]       throw_height_out;
    logic [2:0]       ball_id_out;
    logic             hand_out;
    logic [2:0]       pattern_pos_out;
    logic             error_out;

    typedef struct packed {
        logic [2:0] height;
        logic [2:0] ball;
        logic       hand;
        logic [2:0] pos;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    siteswap_scheduler dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .new_beat         (new_beat),
        .pattern_in       (pattern_in),
        .pattern_length   (pattern_length),
        .pattern_valid_in (pattern_valid_in),
        .num_balls_in     (num_balls_in),
        .throw_valid_out  (throw_valid_out),
        .throw_height_out (throw_height_out),
        .ball_id_out      (ball_id_out),
        .hand_out         (hand_out),
        .pattern_pos_out  (pattern_pos_out),
        .error_out        (error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected throw per valid pulse
    always @(negedge clk_in) begin
        if (!rst_in && throw_valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_throw", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("height", throw_height_out, e.height);
                if (e.height != 3'd0) check("ball_id", ball_id_out, e.ball);
                check("hand", hand_out, e.hand);
                check("pos", pattern_pos_out, e.pos);
                check("error", error_out, e.err);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Leaves new_beat high for exactly one edge; back-to-back calls give consecutive beats
    task automatic beat(input int h, input int b, input int hd, input int p, input int er);
        exp_t e;
        e.height = h[2:0];
        e.ball   = b[2:0];
        e.hand   = hd[0];
        e.pos    = p[2:0];
        e.err    = er[0];
        exp_q.push_back(e);
        new_beat = 1'b1;
        idle(1);
        new_beat = 1'b0;
    endtask

    task automatic load(input int h0, input int h1, input int h2, input int len, input int nb);
        pattern_valid_in = 1'b0;
        idle(2);
        pattern_in       = '0;
        pattern_in[0]    = h0[2:0];
        pattern_in[1]    = h1[2:0];
        pattern_in[2]    = h2[2:0];
        pattern_length   = len[2:0];
        num_balls_in     = nb[2:0];
        pattern_valid_in = 1'b1;
        idle(2);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_valid"},  throw_valid_out,  0);
        check({name, "_height"}, throw_height_out, 0);
        check({name, "_ball"},   ball_id_out,      0);
        check({name, "_hand"},   hand_out,         0);
        check({name, "_pos"},    pattern_pos_out,  0);
        check({name, "_error"},  error_out,        0);
    endtask

    initial begin
        int id441 [7] = '{0, 1, 2, 2, 0, 1, 1};
        int id51  [8] = '{0, 1, 1, 2, 2, 0, 0, 1};
        rst_in           = 1'b1;
        new_beat         = 1'b0;
        pattern_in       = '0;
        pattern_length   = 3'd0;
        pattern_valid_in = 1'b0;
        num_balls_in     = 3'd0;
        idle(3);
        check_quiet("reset");
        rst_in = 1'b0;
        idle(1);

        // "3", three balls
        load(3, 0, 0, 1, 3);
        for (int i = 0; i < 6; i++) beat(3, i % 3, i % 2, 0, 0);
        idle(2);

        // "441", spaced beats
        load(4, 4, 1, 3, 3);
        for (int i = 0; i < 7; i++) begin
            beat((i % 3 == 2) ? 1 : 4, id441[i], i % 2, i % 3, 0);
            idle(1);
        end
        idle(2);

        // "51", consecutive beats
        load(5, 1, 0, 2, 3);
        for (int i = 0; i < 8; i++) beat((i % 2 == 1) ? 1 : 5, id51[i], i % 2, i % 2, 0);
        idle(2);

        // Invalid "30", two balls: drop on beat 3, then an empty throw
        load(3, 0, 0, 2, 2);
        beat(3, 0, 0, 0, 0);
        beat(0, 0, 1, 1, 0);
        beat(3, 1, 0, 0, 0);
        beat(0, 0, 1, 1, 1);
        idle(3);
        check("error_sticky", error_out, 1);
        beat(3, 0, 0, 0, 1);
        idle(2);

        // Drop valid mid-run: everything clears, then restart with "3"
        pattern_valid_in = 1'b0;
        idle(1);
        check_quiet("idle");
        load(3, 0, 0, 1, 3);
        beat(3, 0, 0, 0, 0);
        beat(3, 1, 1, 0, 0);
        idle(2);

        // Async reset mid-cycle during run
        beat(3, 2, 0, 0, 0);
        idle(1);
        #2;
        rst_in           = 1'b1;
        pattern_valid_in = 1'b0;
        #1;
        check_quiet("async_rst");
        idle(2);
        rst_in = 1'b0;
        // Beats while idle produce nothing (monitor flags any pulse)
        new_beat = 1'b1;
        idle(3);
        new_beat = 1'b0;
        // Beat coincident with the valid edge and with LOAD: both ignored
        pattern_in       = '0;
        pattern_in[0]    = 3'd3;
        pattern_length   = 3'd1;
        num_balls_in     = 3'd3;
        pattern_valid_in = 1'b1;
        new_beat         = 1'b1;
        idle(2);
        new_beat = 1'b0;
        idle(1);
        check("load_no_pulse", throw_valid_out, 0);
        beat(3, 0, 0, 0, 0);
        beat(3, 1, 1, 0, 0);
        idle(3);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
